// File: rtl/keypad_debounce_encoder.sv
// Debounces a one-hot keypad vector with a press/release FSM and emits a binary key code.
// Define KEYPAD_DIGIT_MAP_EN (requires N_KEYS == 16) for the digit remap; unmapped keys are ignored.
module keypad_debounce_encoder #(
  parameter int unsigned N_KEYS          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 8,
  localparam int unsigned CODE_W         = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] onehot,
  output logic [CODE_W-1:0] binary,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_err,
  output logic [CNT_W-1:0]  press_count
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DebW-1:0] CntLast = DebW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDebPress, StPressed, StDebRel} state_e;

  state_e             state_q, state_d;
  logic [N_KEYS-1:0]  s_q;
  logic [N_KEYS-1:0]  cand_q, cand_d;
  logic [DebW-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]  bin_q, bin_d;
  logic [CNT_W-1:0]   pc_q, pc_d;
  logic               kv_q, kv_d;
  logic               multi_q;

  function automatic int unsigned popcount(input logic [N_KEYS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(N_KEYS); i++) n += 32'(v[i]);
    return n;
  endfunction

  function automatic logic qualifies(input logic [N_KEYS-1:0] v);
`ifdef KEYPAD_DIGIT_MAP_EN
    // Only the ten digit positions count as keys.
    return (popcount(v) == 32'd1) && ((16'(v) & 16'hEEE8) != 16'h0000);
`else
    return popcount(v) == 32'd1;
`endif
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] code;
    code = '0;
`ifdef KEYPAD_DIGIT_MAP_EN
    case (16'(v))
      16'h0008: code = CODE_W'(0);
      16'h0080: code = CODE_W'(1);
      16'h0040: code = CODE_W'(2);
      16'h0020: code = CODE_W'(3);
      16'h0800: code = CODE_W'(4);
      16'h0400: code = CODE_W'(5);
      16'h0200: code = CODE_W'(6);
      16'h8000: code = CODE_W'(7);
      16'h4000: code = CODE_W'(8);
      16'h2000: code = CODE_W'(9);
      default:  code = '0;
    endcase
`else
    for (int i = 0; i < int'(N_KEYS); i++) begin
      if (v[i]) code = CODE_W'(i);
    end
`endif
    return code;
  endfunction

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    pc_d    = pc_q;
    kv_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (qualifies(s_q)) begin
          cand_d  = s_q;
          cnt_d   = '0;
          state_d = StDebPress;
        end
      end
      StDebPress: begin
        if (s_q != cand_q) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StPressed;
          bin_d   = encode(cand_q);
          kv_d    = 1'b1;
          pc_d    = pc_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + DebW'(1);
        end
      end
      StPressed: begin
        if (s_q != cand_q) begin
          cnt_d   = '0;
          state_d = StDebRel;
        end
      end
      StDebRel: begin
        // A return to the held key resumes without a new strobe.
        if (s_q == cand_q) begin
          state_d = StPressed;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + DebW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      s_q     <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      pc_q    <= '0;
      kv_q    <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= onehot;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      pc_q    <= pc_d;
      kv_q    <= kv_d;
      multi_q <= popcount(s_q) > 32'd1;
    end
  end

  assign binary      = bin_q;
  assign key_valid   = kv_q;
  assign key_held    = (state_q == StPressed) || (state_q == StDebRel);
  assign multi_err   = multi_q;
  assign press_count = pc_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Bench for keypad_debounce_encoder: scoreboard of expected key_valid events (edge, code, count).
// Works with or without KEYPAD_DIGIT_MAP_EN defined.
module tb_keypad_debounce_encoder;
  localparam int unsigned Deb  = 4;
  localparam int unsigned CntW = 2;

  logic            clk    = 1'b0;
  logic            rst    = 1'b1;
  logic [15:0]     onehot = '0;
  logic [3:0]      binary;
  logic            key_valid;
  logic            key_held;
  logic            multi_err;
  logic [CntW-1:0] press_count;

  keypad_debounce_encoder #(
    .N_KEYS          (16),
    .DEBOUNCE_CYCLES (Deb),
    .CNT_W           (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .onehot      (onehot),
    .binary      (binary),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .multi_err   (multi_err),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]     edge_n;
    logic [3:0]      code;
    logic [CntW-1:0] cnt;
  } ev_t;

  int unsigned     cyc = 0;
  ev_t             exp_q[$];
  ev_t             obs_q[$];
  logic            kv_prev = 1'b0;
  int unsigned     b2b = 0;
  int unsigned     n_checks = 0;
  int unsigned     n_pass = 0;
  logic [3:0]      exp_bin = '0;
  logic [CntW-1:0] exp_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) obs_q.push_back(ev_t'{edge_n: cyc, code: binary, cnt: press_count});
    if (key_valid && kv_prev) b2b <= b2b + 1;
    kv_prev <= key_valid;
  end

  function automatic logic model_qualifies(input logic [15:0] v);
`ifdef KEYPAD_DIGIT_MAP_EN
    return ($countones(v) == 1) && ((v & 16'hEEE8) != 16'h0000);
`else
    return $countones(v) == 1;
`endif
  endfunction

  function automatic logic [3:0] model_code(input logic [15:0] v);
`ifdef KEYPAD_DIGIT_MAP_EN
    case (v)
      16'h0008: return 4'd0;
      16'h0080: return 4'd1;
      16'h0040: return 4'd2;
      16'h0020: return 4'd3;
      16'h0800: return 4'd4;
      16'h0400: return 4'd5;
      16'h0200: return 4'd6;
      16'h8000: return 4'd7;
      16'h4000: return 4'd8;
      16'h2000: return 4'd9;
      default:  return 4'd0;
    endcase
`else
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'd0;
`endif
  endfunction

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives v from the IDLE state and predicts the strobe on edge Deb+2.
  task automatic press(input logic [15:0] v, input int unsigned hold);
    onehot = v;
    if (model_qualifies(v)) begin
      exp_cnt = exp_cnt + 1'b1;
      exp_bin = model_code(v);
      exp_q.push_back(ev_t'{edge_n: cyc + Deb + 2, code: exp_bin, cnt: exp_cnt});
    end
    step(hold);
  endtask

  task automatic release_key();
    onehot = '0;
    step(Deb + 4);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    onehot = '0;
    step(2);
    n_checks += 5;
    if (binary !== 4'd0) $display("FAIL reset_binary: got %0d want 0", binary);
    else n_pass++;
    if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b want 0", key_valid);
    else n_pass++;
    if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b want 0", key_held);
    else n_pass++;
    if (multi_err !== 1'b0) $display("FAIL reset_multi_err: got %b want 0", multi_err);
    else n_pass++;
    if (press_count !== '0) $display("FAIL reset_press_count: got %0d want 0", press_count);
    else n_pass++;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_clean_press();
    press(16'h0020, 10);
    n_checks += 3;
    if (key_held !== 1'b1) $display("FAIL clean_key_held: got %b want 1", key_held);
    else n_pass++;
    if (binary !== exp_bin) $display("FAIL clean_binary: got %0d want %0d", binary, exp_bin);
    else n_pass++;
    if (press_count !== exp_cnt)
      $display("FAIL clean_count: got %0d want %0d", press_count, exp_cnt);
    else n_pass++;
    // Release: still held on edge Deb+1, idle on edge Deb+2.
    onehot = '0;
    step(Deb + 1);
    n_checks++;
    if (key_held !== 1'b1) $display("FAIL release_early: got %b want 1", key_held);
    else n_pass++;
    step(1);
    n_checks += 2;
    if (key_held !== 1'b0) $display("FAIL release_idle: got %b want 0", key_held);
    else n_pass++;
    if (binary !== exp_bin) $display("FAIL release_binary_hold: got %0d want %0d", binary, exp_bin);
    else n_pass++;
    step(2);
  endtask

  task automatic test_bounce();
    onehot = 16'h0040;
    step(3);
    onehot = '0;
    step(1);
    press(16'h0040, 10);
    n_checks++;
    if (binary !== exp_bin) $display("FAIL bounce_binary: got %0d want %0d", binary, exp_bin);
    else n_pass++;
    release_key();
  endtask

  task automatic test_multi_key();
    onehot = 16'h0048;
    step(1);
    n_checks++;
    if (multi_err !== 1'b0) $display("FAIL multi_latency_early: got %b want 0", multi_err);
    else n_pass++;
    step(1);
    n_checks++;
    if (multi_err !== 1'b1) $display("FAIL multi_err_set: got %b want 1", multi_err);
    else n_pass++;
    step(8);
    n_checks++;
    if (key_held !== 1'b0) $display("FAIL multi_no_hold: got %b want 0", key_held);
    else n_pass++;
    press(16'h0008, 10);
    n_checks += 2;
    if (binary !== exp_bin) $display("FAIL multi_then_single: got %0d want %0d", binary, exp_bin);
    else n_pass++;
    if (multi_err !== 1'b0) $display("FAIL multi_err_clear: got %b want 0", multi_err);
    else n_pass++;
    release_key();
  endtask

  task automatic test_unmapped();
    logic want_held;
    want_held = model_qualifies(16'h0001);
    press(16'h0001, 20);
    n_checks += 2;
    if (binary !== exp_bin) $display("FAIL unmapped_binary: got %0d want %0d", binary, exp_bin);
    else n_pass++;
    if (key_held !== want_held) $display("FAIL unmapped_held: got %b want %b", key_held, want_held);
    else n_pass++;
    release_key();
    press(16'h8000, 10);
    n_checks++;
    if (binary !== exp_bin) $display("FAIL key15_binary: got %0d want %0d", binary, exp_bin);
    else n_pass++;
    release_key();
  endtask

  task automatic test_reset_mid_hold();
    press(16'h0200, 10);
    n_checks++;
    if (key_held !== 1'b1) $display("FAIL midhold_pre: got %b want 1", key_held);
    else n_pass++;
    rst = 1'b1;
    onehot = '0;
    step(1);
    exp_cnt = '0;
    exp_bin = '0;
    n_checks += 3;
    if (key_held !== 1'b0) $display("FAIL midhold_key_held: got %b want 0", key_held);
    else n_pass++;
    if (binary !== 4'd0) $display("FAIL midhold_binary: got %0d want 0", binary);
    else n_pass++;
    if (press_count !== '0) $display("FAIL midhold_count: got %0d want 0", press_count);
    else n_pass++;
    rst = 1'b0;
    step(3);
  endtask

  task automatic test_wrap();
    logic [15:0] keys [5];
    keys = '{16'h0008, 16'h0080, 16'h0040, 16'h0020, 16'h0800};
    for (int i = 0; i < 5; i++) begin
      press(keys[i], 8);
      release_key();
    end
    n_checks += 2;
    if (press_count !== exp_cnt) $display("FAIL wrap_model: got %0d want %0d", press_count, exp_cnt);
    else n_pass++;
    if (press_count !== 2'd1) $display("FAIL wrap_value: got %0d want 1", press_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned rd;
    ev_t e;
    ev_t o;
    rd = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rd >= obs_q.size()) begin
        $display("FAIL sb_missing: got no strobe want edge %0d code %0d count %0d",
                 e.edge_n, e.code, e.cnt);
      end else begin
        o = obs_q[rd];
        rd++;
        if (o !== e)
          $display("FAIL sb_event: got edge %0d code %0d count %0d want edge %0d code %0d count %0d",
                   o.edge_n, o.code, o.cnt, e.edge_n, e.code, e.cnt);
        else n_pass++;
      end
    end
    n_checks += 2;
    if (obs_q.size() != rd) $display("FAIL sb_extra: got %0d strobes want %0d", obs_q.size(), rd);
    else n_pass++;
    if (b2b != 0) $display("FAIL back_to_back: got %0d adjacent strobes want 0", b2b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_unmapped();
    test_reset_mid_hold();
    test_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_debounce_encoder.md
# keypad_debounce_encoder

- Parametrised successor to the keypad one-hot encoder.
- Takes the keypad scanner's N-key one-hot vector and debounces it with a press/release state machine.
- On each qualified press: emits a binary key code with a one-cycle `key_valid` strobe, holds the code until the next press, counts presses and flags multi-key input.
- Sits between the keypad scanner and the display/entry logic.

## Interface
- `N_KEYS`, default 16: width of the one-hot input (≥2).
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable cycles required to accept a press or a release (≥1).
- `CNT_W`, default 8: width of `press_count`.
- `CODE_W`, derived `$clog2(N_KEYS)`: width of `binary`. Not overridable.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `onehot` in N_KEYS: raw key vector; bit i high = key i pressed.
- `binary` out CODE_W: code of the last accepted key; holds between presses.
- `key_valid` out 1: one-cycle pulse on press acceptance.
- `key_held` out 1: high while an accepted key is still considered down.
- `multi_err` out 1: high when the sampled input has two or more bits set.
- `press_count` out CNT_W: number of accepted presses, wraps modulo 2^CNT_W.

## Operation
- **Input sampling:** `onehot` is registered into `s` every cycle. All decisions use `s`, never the raw input.
- **States:** IDLE, DEB_PRESS, PRESSED, DEB_REL. A register `cand` holds the candidate key vector; a debounce counter `cnt` tracks stable cycles.
- **IDLE:**
  - If `s` has exactly one bit set (and, in map mode, that bit is mapped): `cand<=s`, `cnt<=0`, go to DEB_PRESS.
  - Otherwise stay.
- **DEB_PRESS:**
  - If `s!=cand`: go to IDLE.
  - Else if `cnt==DEBOUNCE_CYCLES-1`: go to PRESSED, `binary<=encode(cand)`, pulse `key_valid`, `press_count<=press_count+1`.
  - Else `cnt<=cnt+1`.
- **PRESSED:** `key_held=1`. If `s!=cand` (release, bounce, or a different key): `cnt<=0`, go to DEB_REL.
- **DEB_REL:**
  - If `s==cand`: return to PRESSED. No new strobe and no count change.
  - Else if `cnt==DEBOUNCE_CYCLES-1`: go to IDLE.
  - Else `cnt<=cnt+1`.
- **Key held across release:** while in DEB_REL, `key_held` stays 1 until the transition to IDLE.
- **Key change without release:** a direct change from key A to key B passes through DEB_REL → IDLE before B is debounced. B therefore needs a full release debounce plus a full press debounce.
- **`multi_err`:** registered popcount(`s`)>1, updated every cycle in every state. It does not alter state-machine transitions beyond the rules above; a multi-bit `s` simply never equals `cand`.
- **`binary` hold:** `binary` changes only on press acceptance. Key-up never clears it.
- **Counter width:** `cnt` is sized `$clog2(DEBOUNCE_CYCLES)+1` bits and never exceeds DEBOUNCE_CYCLES-1.
- **Reset:** `rst` mid-operation forces IDLE and clears all registers in the same edge, aborting any debounce or held key.

## Timing
- **Reset values:** `binary`=0, `key_valid`=0, `key_held`=0, `multi_err`=0, `press_count`=0; `s`, `cand`, `cnt` also cleared.
- **Press latency:** number edges from the first rising edge that samples a new stable key as edge 1. `key_valid`, `binary` and the `press_count` increment all update on edge DEBOUNCE_CYCLES+2.
- **`key_valid` width:** exactly one cycle per accepted press, never back-to-back.
- **Release latency:** IDLE (`key_held`=0) is reached on edge DEBOUNCE_CYCLES+2 after the first edge sampling the key-up vector.
- **Bounce:** any single-cycle deviation restarts the counter; there is no partial credit.
- **`multi_err` latency:** 2 cycles after `onehot`.
- **Counter wrap:** `press_count` rolls from 2^CNT_W−1 to 0 without an error flag.

## Configuration
- **`KEYPAD_DIGIT_MAP_EN` defined:**
  - N_KEYS must be 16 and CODE_W is 4.
  - Digit remap: bit3→0, bit7→1, bit6→2, bit5→3, bit11→4, bit10→5, bit9→6, bit15→7, bit14→8, bit13→9.
  - The other six keys are unmapped: treated as no key and never enter DEB_PRESS. They still contribute to `multi_err`.
- **Macro undefined:** `binary` = index of the set bit (bit i → i), and every key qualifies.

## Test plan
- **Reset:** `rst` high 2 cycles → all outputs 0.
- **Clean press** (DEBOUNCE_CYCLES=4, macro off): `onehot`=16'h0020 held 10 cycles → `key_valid` pulse on edge 6, `binary`=5, `press_count`=1, `key_held`=1.
- **Bounce:** 16'h0040 for 3 cycles, 0 for 1 cycle, then 16'h0040 stable → exactly one `key_valid`, on edge 6 after the restart, `binary`=6.
- **Multi-key:** `onehot`=16'h0048 → `multi_err`=1 two cycles later, no `key_valid`. Then 16'h0008 stable → `binary`=3.
- **Map mode** (macro defined, D=4):
  - 16'h8000 → `binary`=7.
  - 16'h0001 held 20 cycles → no `key_valid`, `binary` unchanged.
- **Reset mid-hold and wrap:**
  - Assert `rst` while PRESSED → `key_held`=0 next edge.
  - With CNT_W=2: five accepted presses → `press_count`=1.
